// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand-mux selects and hazard stall
// Optional: define BYPASS_EN to forward from EX/MEM and MEM/WB; otherwise every hazard stalls.
module ex_operand_stage #(
   parameter int DATA_BITS = 32,
   parameter int REG_BITS  = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 id_valid,
   input  logic [REG_BITS-1:0]  id_rs,
   input  logic [REG_BITS-1:0]  id_rt,
   input  logic                 id_rs_used,
   input  logic                 id_rt_used,
   input  logic [DATA_BITS-1:0] id_rs_data,
   input  logic [DATA_BITS-1:0] id_rt_data,
   input  logic [DATA_BITS-1:0] id_imm,
   input  logic                 id_alusrc,
   input  logic                 id_wreg,
   input  logic [REG_BITS-1:0]  id_wdst,
   input  logic                 id_is_load,
   input  logic                 flush,
   output logic                 id_stall,
   output logic                 ex_valid,
   output logic                 ex_wreg,
   output logic                 ex_is_load,
   output logic [REG_BITS-1:0]  ex_wdst,
   output logic [DATA_BITS-1:0] ex_rs_data,
   output logic [DATA_BITS-1:0] ex_rt_data,
   output logic [DATA_BITS-1:0] ex_imm,
   output logic [1:0]           ex_sel_a,
   output logic [1:0]           ex_sel_b
);
   localparam logic [1:0] SEL_REG = 2'b00;
   localparam logic [1:0] SEL_EXM = 2'b01;
   localparam logic [1:0] SEL_MWB = 2'b10;
   localparam logic [1:0] SEL_IMM = 2'b11;

   logic                mem_wreg;
   logic [REG_BITS-1:0] mem_wdst;
   logic                ex_hz, mem_hz;
   logic                rs_ex, rt_ex, rs_mem, rt_mem;
   logic                bubble;
   logic [1:0]          sel_a_d, sel_b_d;

   always_comb begin
      // Writes to r0 are discarded by the register file, so they never form a hazard.
      ex_hz  = ex_wreg && (ex_wdst != '0);
      mem_hz = mem_wreg && (mem_wdst != '0);
      rs_ex  = id_rs_used && ex_hz  && (id_rs == ex_wdst);
      rt_ex  = id_rt_used && ex_hz  && (id_rt == ex_wdst);
      rs_mem = id_rs_used && mem_hz && (id_rs == mem_wdst);
      rt_mem = id_rt_used && mem_hz && (id_rt == mem_wdst);
`ifdef BYPASS_EN
      sel_a_d  = rs_ex ? SEL_EXM : (rs_mem ? SEL_MWB : SEL_REG);
      sel_b_d  = id_alusrc ? SEL_IMM : (rt_ex ? SEL_EXM : (rt_mem ? SEL_MWB : SEL_REG));
      id_stall = id_valid && ex_valid && ex_is_load && (rs_ex || rt_ex) && !flush;
`else
      sel_a_d  = SEL_REG;
      sel_b_d  = id_alusrc ? SEL_IMM : SEL_REG;
      id_stall = id_valid && (rs_ex || rt_ex || rs_mem || rt_mem) && !flush;
`endif
      bubble = flush || id_stall;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wreg   <= 1'b0;
         mem_wdst   <= '0;
         ex_valid   <= 1'b0;
         ex_wreg    <= 1'b0;
         ex_is_load <= 1'b0;
         ex_wdst    <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_sel_a   <= SEL_REG;
         ex_sel_b   <= SEL_REG;
      end else begin
         // The shadow keeps advancing through stalls so the bubble reaches MEM on time.
         mem_wreg <= ex_wreg;
         mem_wdst <= ex_wdst;
         if (bubble) begin
            ex_valid   <= 1'b0;
            ex_wreg    <= 1'b0;
            ex_is_load <= 1'b0;
            ex_wdst    <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_sel_a   <= SEL_REG;
            ex_sel_b   <= SEL_REG;
         end else begin
            ex_valid   <= id_valid;
            ex_wreg    <= id_wreg && id_valid;
            ex_is_load <= id_is_load && id_valid;
            ex_wdst    <= id_wdst;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_sel_a   <= sel_a_d;
            ex_sel_b   <= sel_b_d;
         end
      end
   end
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage against an instruction-level model
module tb_ex_operand_stage;
   localparam int N_DIR   = 21;
   localparam int N_CYCLE = 2000;

   typedef struct {
      bit        valid, wreg, load, alusrc, rs_used, rt_used;
      bit [4:0]  rs, rt, wdst;
      bit [31:0] rsd, rtd, imm;
   } instr_t;

   typedef struct {
      bit        stall;
      bit        valid, wreg, load;
      bit [4:0]  wdst;
      bit [31:0] rsd, rtd, imm;
      bit [1:0]  sa, sb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_rs_used, id_rt_used, id_alusrc, id_wreg, id_is_load, flush;
   logic [4:0]  id_rs, id_rt, id_wdst;
   logic [31:0] id_rs_data, id_rt_data, id_imm;
   logic        id_stall, ex_valid, ex_wreg, ex_is_load;
   logic [4:0]  ex_wdst;
   logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
   logic [1:0]  ex_sel_a, ex_sel_b;

   int   tests = 0;
   int   fails = 0;
   exp_t sbq[$];

   exp_t     m_ex;
   bit       m_mem_w;
   bit [4:0] m_mem_d;

   ex_operand_stage dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_rs_data(id_rs_data),
      .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alusrc(id_alusrc), .id_wreg(id_wreg),
      .id_wdst(id_wdst), .id_is_load(id_is_load), .flush(flush), .id_stall(id_stall),
      .ex_valid(ex_valid), .ex_wreg(ex_wreg), .ex_is_load(ex_is_load), .ex_wdst(ex_wdst),
      .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
      .ex_sel_a(ex_sel_a), .ex_sel_b(ex_sel_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic instr_t mk(bit [4:0] rs, bit [4:0] rt, bit [4:0] wdst,
                                 bit wreg, bit load, bit alusrc);
      instr_t i;
      i.valid = 1'b1; i.rs_used = 1'b1; i.rt_used = 1'b1;
      i.rs = rs; i.rt = rt; i.wdst = wdst;
      i.wreg = wreg; i.load = load; i.alusrc = alusrc;
      i.rsd = $urandom; i.rtd = $urandom; i.imm = $urandom;
      return i;
   endfunction

   function automatic instr_t rnd_instr();
      instr_t i;
      i = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
      i.valid   = $urandom_range(0, 9) != 0;
      i.rs_used = $urandom_range(0, 6) != 0;
      i.rt_used = $urandom_range(0, 6) != 0;
      return i;
   endfunction

   // Which older in-flight instruction produces register r: 1 = the one in EX, 2 = the one in MEM.
   function automatic bit [1:0] producer(bit used, bit [4:0] r);
      if (!used || r == 5'd0) return 2'd0;
      if (m_ex.wreg && m_ex.wdst == r) return 2'd1;
      if (m_mem_w && m_mem_d == r) return 2'd2;
      return 2'd0;
   endfunction

   function automatic exp_t model_step(instr_t i, bit r, bit f);
      exp_t     nx;
      bit       stall;
      bit [1:0] pa, pb;
      pa = producer(i.rs_used, i.rs);
      pb = producer(i.rt_used, i.rt);
`ifdef BYPASS_EN
      stall = i.valid && m_ex.valid && m_ex.load && (pa == 2'd1 || pb == 2'd1);
`else
      stall = i.valid && (pa != 2'd0 || pb != 2'd0);
      pa = 2'd0;
      pb = 2'd0;
`endif
      if (f) stall = 1'b0;
      nx = '{default: 0};
      if (!r && !f && !stall) begin
         nx.valid = i.valid;
         nx.wreg  = i.valid && i.wreg;
         nx.load  = i.valid && i.load;
         nx.wdst  = i.wdst;
         nx.rsd   = i.rsd;
         nx.rtd   = i.rtd;
         nx.imm   = i.imm;
         nx.sa    = pa;
         nx.sb    = i.alusrc ? 2'd3 : pb;
      end
      m_mem_w = r ? 1'b0 : m_ex.wreg;
      m_mem_d = r ? 5'd0 : m_ex.wdst;
      m_ex    = nx;
      nx.stall = stall;
      return nx;
   endfunction

   initial begin
      exp_t   e;
      logic   s_stall;
      forever begin
         @(negedge clk);
         #3 s_stall = id_stall;
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("id_stall",   32'(s_stall),    32'(e.stall));
            chk("ex_valid",   32'(ex_valid),   32'(e.valid));
            chk("ex_wreg",    32'(ex_wreg),    32'(e.wreg));
            chk("ex_is_load", 32'(ex_is_load), 32'(e.load));
            chk("ex_wdst",    32'(ex_wdst),    32'(e.wdst));
            chk("ex_rs_data", ex_rs_data,      e.rsd);
            chk("ex_rt_data", ex_rt_data,      e.rtd);
            chk("ex_imm",     ex_imm,          e.imm);
            chk("ex_sel_a",   32'(ex_sel_a),   32'(e.sa));
            chk("ex_sel_b",   32'(ex_sel_b),   32'(e.sb));
         end
      end
   end

   initial begin
      instr_t cur;
      bit     r, f, prev_stall;
      exp_t   e;
      m_ex = '{default: 0};
      m_mem_w = 1'b0;
      m_mem_d = 5'd0;
      prev_stall = 1'b0;
      cur = mk(0, 0, 0, 0, 0, 0);
      cur.valid = 1'b0;
      rst = 1'b1; flush = 1'b0;
      id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_alusrc = 1'b0;
      id_wreg = 1'b0; id_wdst = '0; id_is_load = 1'b0;
      for (int c = 0; c < N_CYCLE; c++) begin
         @(negedge clk);
         r = 1'b0;
         f = 1'b0;
         if (c < N_DIR) begin
            case (c)
               0:  r = 1'b1;
               1:  cur = mk(1, 2, 3, 1, 0, 0);
               2:  cur = mk(3, 4, 6, 1, 0, 0);
               5:  cur = mk(1, 2, 5, 1, 1, 0);
               6:  cur = mk(2, 5, 8, 1, 0, 0);
               9:  cur = mk(1, 2, 5, 1, 1, 0);
               10: begin cur = mk(2, 5, 8, 1, 0, 0); f = 1'b1; end
               11: cur = mk(1, 2, 3, 1, 0, 0);
               12: cur = mk(3, 1, 4, 1, 0, 0);
               13: r = 1'b1;
               15: cur = mk(1, 2, 7, 1, 0, 0);
               16: cur = mk(1, 2, 7, 1, 0, 0);
               17: cur = mk(1, 7, 9, 1, 0, 0);
               18: cur = mk(7, 7, 9, 1, 0, 1);
               19: cur = mk(1, 2, 0, 1, 0, 0);
               20: cur = mk(0, 1, 2, 1, 0, 0);
               default: ;
            endcase
         end else begin
            if (!prev_stall) cur = rnd_instr();
            r = $urandom_range(0, 49) == 0;
            f = $urandom_range(0, 11) == 0;
         end
         rst = r; flush = f;
         id_valid = cur.valid; id_rs = cur.rs; id_rt = cur.rt;
         id_rs_used = cur.rs_used; id_rt_used = cur.rt_used;
         id_rs_data = cur.rsd; id_rt_data = cur.rtd; id_imm = cur.imm;
         id_alusrc = cur.alusrc; id_wreg = cur.wreg; id_wdst = cur.wdst; id_is_load = cur.load;
         e = model_step(cur, r, f);
         prev_stall = e.stall;
         sbq.push_back(e);
      end
      @(posedge clk);
      #2;
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
